// File: rtl/cpu_input_port_if.sv
// Bundles the producer-side and CPU-side signals of the 4-bit input port.
// slave modport: the port itself. master modport: the producer and CPU driving it.
// drop_cnt exists only when CPU_INPUT_PORT_DROP_CNT_EN is defined.
interface cpu_input_port_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] ext_data;
    logic             ext_stb;
    logic             rd_en;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [CW-1:0]    count;
    logic             ovf_flag;
    logic             ovf_clr;
`ifdef CPU_INPUT_PORT_DROP_CNT_EN
    logic [3:0]       drop_cnt;

    modport master (output ext_data, ext_stb, rd_en, ovf_clr,
                    input  rd_data, empty, full, count, ovf_flag, drop_cnt);
    modport slave  (input  ext_data, ext_stb, rd_en, ovf_clr,
                    output rd_data, empty, full, count, ovf_flag, drop_cnt);
`else
    modport master (output ext_data, ext_stb, rd_en, ovf_clr,
                    input  rd_data, empty, full, count, ovf_flag);
    modport slave  (input  ext_data, ext_stb, rd_en, ovf_clr,
                    output rd_data, empty, full, count, ovf_flag);
`endif
endinterface

// File: rtl/cpu_input_port.sv
// Input port of the 4-bit CPU: synchronizes an async nibble+strobe, edge-detects, queues in a FIFO.
// Latency: strobe rise before edge E1 is written at edge E(SYNC_STAGES+1); rd_data is show-ahead.
// Backpressure: none toward the producer; a strobe into a full FIFO (no same-cycle pop) is dropped
// and sets sticky ovf_flag. Optional CPU_INPUT_PORT_DROP_CNT_EN adds a saturating 4-bit drop_cnt.
module cpu_input_port #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic           clk,
    input logic           reset,
    cpu_input_port_if.slave port
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [SYNC_STAGES-1:0] stb_sync_q, stb_sync_d;
    logic [WIDTH-1:0]       data_sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]       data_sync_d [SYNC_STAGES];
    logic                   stb_prev_q, stb_prev_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [WIDTH-1:0]       mem_d [DEPTH];
    logic                   ovf_q, ovf_d;
`ifdef CPU_INPUT_PORT_DROP_CNT_EN
    logic [3:0]             drop_cnt_q, drop_cnt_d;
`endif

    logic empty, full, wr_evt, do_rd, do_wr, drop;

    // Shift the async strobe and data through the synchronizer chain; keep last synced strobe.
    always_comb begin
        stb_sync_d     = {stb_sync_q[SYNC_STAGES-2:0], port.ext_stb};
        data_sync_d[0] = port.ext_data;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            data_sync_d[i] = data_sync_q[i-1];
        end
        stb_prev_d = stb_sync_q[SYNC_STAGES-1];
    end

    // Status from registered pointers, and the write/read/drop decisions for this cycle.
    always_comb begin
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        wr_evt = stb_sync_q[SYNC_STAGES-1] & ~stb_prev_q;
        // A pop on a full FIFO frees the slot the concurrent write needs.
        do_rd  = port.rd_en & ~empty;
        do_wr  = wr_evt & (~full | do_rd);
        drop   = wr_evt & full & ~do_rd;
    end

    // Next-state of storage, pointers and overflow reporting; a drop beats a same-cycle clear.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = data_sync_q[SYNC_STAGES-1];
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (port.ovf_clr) begin
            ovf_d = 1'b0;
        end
`ifdef CPU_INPUT_PORT_DROP_CNT_EN
        drop_cnt_d = drop_cnt_q;
        if (port.ovf_clr) begin
            drop_cnt_d = drop ? 4'd1 : 4'd0;
        end else if (drop && drop_cnt_q != 4'hF) begin
            drop_cnt_d = drop_cnt_q + 4'd1;
        end
`endif
    end

    // All state registers; reset discards queued data immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stb_sync_q <= '0;
            stb_prev_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ovf_q      <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync_q[i] <= '0;
            end
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
`ifdef CPU_INPUT_PORT_DROP_CNT_EN
            drop_cnt_q <= 4'd0;
`endif
        end else begin
            stb_sync_q  <= stb_sync_d;
            stb_prev_q  <= stb_prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            ovf_q       <= ovf_d;
            data_sync_q <= data_sync_d;
            mem_q       <= mem_d;
`ifdef CPU_INPUT_PORT_DROP_CNT_EN
            drop_cnt_q  <= drop_cnt_d;
`endif
        end
    end

    assign port.rd_data  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
    assign port.empty    = empty;
    assign port.full     = full;
    assign port.count    = wr_ptr_q - rd_ptr_q;
    assign port.ovf_flag = ovf_q;
`ifdef CPU_INPUT_PORT_DROP_CNT_EN
    assign port.drop_cnt = drop_cnt_q;
`endif
endmodule

// File: doc/cpu_input_port.md
Name: cpu_input_port

Overview:
- Input-side port of the 4-bit processor; the reading counterpart to the CPU output register.
- An external producer (switches, keypad, test harness) presents a nibble and pulses a strobe; the block synchronizes, edge-detects and queues each nibble in a small FIFO.
- The CPU pops one nibble per IN instruction during its execute phase and loads it into the accumulator.

Parameters:
- WIDTH, 4, data nibble width in bits
- DEPTH, 4, FIFO entries; power of 2, minimum 2
- SYNC_STAGES, 2, synchronizer flops on ext_stb and ext_data; minimum 2

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- ext_data  input  WIDTH  external nibble, asynchronous to clk
- ext_stb  input  1  external write strobe, asynchronous, level
- rd_en  input  1  CPU pop request; sampled on clk rising edge
- rd_data  output  WIDTH  head-of-FIFO nibble (show-ahead); 0 when empty
- empty  output  1  FIFO holds no entries
- full  output  1  FIFO holds DEPTH entries
- count  output  $clog2(DEPTH)+1  current occupancy
- ovf_flag  output  1  sticky: a strobe arrived while full
- ovf_clr  input  1  synchronous clear of ovf_flag

Behaviour:
- Interface decision: reset reset, asynchronous, active-high; clock clk.
- Reset: all synchronizer flops, edge register, pointers and storage go to 0. Outputs: rd_data=0, empty=1, full=0, count=0, ovf_flag=0.
- Reset asserted mid-operation discards all queued data immediately (asynchronous).
- Synchronizer: ext_stb and every ext_data bit pass through SYNC_STAGES flops. One further flop holds the previous synced strobe.
- Edge detect: wr_evt = stb_sync & ~stb_prev. Exactly one event per rising edge of ext_stb, regardless of strobe length.
- Producer contract: ext_data is held stable from ≥SYNC_STAGES+1 cycles before the ext_stb rise until ext_stb falls. Minimum ext_stb high time and low time is SYNC_STAGES+1 cycles each.
- Latency: if ext_stb rises before edge E1, the entry is written at edge E(SYNC_STAGES+1). With defaults, empty falls after the 3rd edge.
- Write rules on wr_evt:
  - Not full: storage[wr_ptr] <= synced data, wr_ptr++.
  - Full and no pop in the same cycle: data dropped, ovf_flag <= 1.
- Read rules on rd_en:
  - Not empty: rd_ptr++. rd_data is combinational from storage[rd_ptr]; the CPU captures rd_data on the same edge that pops it.
  - Empty: no state change, rd_data stays 0. Not an error.
- Simultaneous wr_evt and rd_en:
  - Full: the pop frees a slot, the write is accepted, count unchanged, no overflow.
  - Empty: the write is accepted, the read is ignored, count becomes 1.
  - Otherwise: both performed, count unchanged.
- Pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH.
  - empty when pointers are equal.
  - full when the MSBs differ and the remaining bits are equal.
  - count = wr_ptr - rd_ptr, modulo 2*DEPTH.
- ovf_flag: set by a dropped write, cleared by ovf_clr. If both occur in the same cycle, set wins.
- empty, full and count are registered-state derived, glitch-free, and valid in the cycle after each edge.

Optional Feature:
- Macro: CPU_INPUT_PORT_DROP_CNT_EN
- Defined: adds output drop_cnt (4 bits, reset 0).
  - Increments on every dropped write and saturates at 15.
  - Cleared by ovf_clr in the same cycle ovf_flag clears. If a drop coincides with ovf_clr, drop_cnt becomes 1.
- Undefined: port and counter are absent; only the sticky ovf_flag reports overflow.

Test Plan:
- Reset then idle: empty=1, full=0, count=0, rd_data=0, ovf_flag=0. Pulse rd_en on empty → no change, rd_data stays 0.
- ext_data=0xA, ext_stb high for 5 cycles → empty falls exactly 3 edges after the first sampled high, count=1, rd_data=0xA; holding ext_stb produces no second entry. rd_en for 1 cycle → empty=1.
- Strobe in 0x1, 0x2, 0x3, 0x4 → full=1, count=4. Fifth strobe with 0x5 → dropped, ovf_flag=1. Four pops return 1, 2, 3, 4 in order. ovf_clr → ovf_flag=0.
- Full FIFO holding 1,2,3,4; align rd_en with the wr_evt cycle of 0x9 → no overflow, count stays 4. Pops return 2, 3, 4, 9.
- Pointer wrap: 10 alternating write/pop pairs of values 0..9 → every pop returns the matching value, count never exceeds 1.
- Assert reset with count=3 mid-strobe → all outputs return to reset values immediately; a later strobe of 0x6 yields count=1, rd_data=0x6.
- With CPU_INPUT_PORT_DROP_CNT_EN defined: 20 strobes into a full FIFO → drop_cnt=15 (saturated). ovf_clr → drop_cnt=0, ovf_flag=0.
